// File: rtl/control_sequencer.sv
// control_sequencer
// Multi-cycle control FSM for the 16-bit accumulator CPU. It steps each
// instruction through FETCH, DECODE, then EXEC or MEM (plus WB), and drives
// the datapath write strobes and mux selects. Instruction and data memory
// use a req/ready handshake. A request held for TIMEOUT_CYCLES cycles
// without ready sends the sequencer to a sticky ERROR state.
//
// Ports
//   clock_in, reset_in       clock (rising edge), synchronous active-low reset
//   run_in                   start execution from IDLE
//   op_code                  opcode field of IR, latched in DECODE
//   status_Z_in/status_N_in  ALU flags, sampled in EXEC for branches
//   instr_mem_ready_in       instruction word valid (FETCH only)
//   data_mem_ready_in        data access complete (MEM only)
//   instr_mem_req_out, data_memory_req_out, data_memory_wr_out
//   branch_out, sel_A_out, sel_B_out, alu_op_out   datapath selects
//   acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out register write strobes
//   halted_out, bus_error_out, state_out           status
//
// Optional build macro CTRL_SEQ_SINGLE_STEP_EN adds step_mode_in. When
// step_mode_in is 1, every completed instruction parks in IDLE instead of
// FETCH, so each run_in pulse executes exactly one instruction.
//
// Opcodes: HLT=0 STO=1 LD=2 LDI=3 ADD=4 ADDI=5 SUB=6 SUBI=7
//          BEQ=8 BNE=9 BGT=10 BGE=11 BLT=12 BLE=13 JMP=14, 15+ illegal.
module control_sequencer #(
    parameter int OPCODE_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    run_in,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    input  logic                    step_mode_in,
`endif
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic                    status_Z_in,
    input  logic                    status_N_in,
    input  logic                    instr_mem_ready_in,
    input  logic                    data_mem_ready_in,
    output logic                    instr_mem_req_out,
    output logic                    data_memory_req_out,
    output logic                    data_memory_wr_out,
    output logic                    branch_out,
    output logic [1:0]              sel_A_out,
    output logic                    sel_B_out,
    output logic                    alu_op_out,
    output logic                    acc_wr_out,
    output logic                    pc_wr_out,
    output logic                    status_wr_out,
    output logic                    ir_wr_out,
    output logic                    halted_out,
    output logic                    bus_error_out,
    output logic [2:0]              state_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

    // The counter reads k-1 during the k-th cycle of a request. Being at
    // CNT_LAST with no ready therefore means TIMEOUT_CYCLES cycles have been spent.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state, nxt, done_st;
    logic [CNT_W-1:0]         wait_cnt;
    logic [OPCODE_WIDTH-1:0]  op_q;
    logic                     taken;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
    assign done_st = step_mode_in ? S_IDLE : S_FETCH;
`else
    assign done_st = S_FETCH;
`endif

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE)
                op_q <= op_code;
            if ((nxt == S_FETCH || nxt == S_MEM) && nxt != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH && !instr_mem_ready_in) ||
                     (state == S_MEM   && !data_mem_ready_in))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        case (op_q)
            OP_BEQ:  taken = status_Z_in;
            OP_BNE:  taken = !status_Z_in;
            OP_BGT:  taken = !status_Z_in && !status_N_in;
            OP_BGE:  taken = !status_N_in;
            OP_BLT:  taken = status_N_in;
            OP_BLE:  taken = status_Z_in || status_N_in;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt                 = state;
        instr_mem_req_out   = 1'b0;
        data_memory_req_out = 1'b0;
        data_memory_wr_out  = 1'b0;
        branch_out          = 1'b0;
        sel_A_out           = 2'b00;
        sel_B_out           = 1'b0;
        alu_op_out          = 1'b0;
        acc_wr_out          = 1'b0;
        pc_wr_out           = 1'b0;
        status_wr_out       = 1'b0;
        ir_wr_out           = 1'b0;
        halted_out          = 1'b0;
        bus_error_out       = 1'b0;
        state_out           = state;

        case (state)
            S_IDLE: if (run_in) nxt = S_FETCH;
            S_FETCH: begin
                instr_mem_req_out = 1'b1;
                if (instr_mem_ready_in) begin
                    ir_wr_out = 1'b1;
                    pc_wr_out = 1'b1;
                    nxt       = S_DECODE;
                end else if (wait_cnt == CNT_LAST) begin
                    nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                case (op_code)
                    OP_HLT:                      nxt = S_HALT;
                    OP_STO, OP_LD, OP_ADD, OP_SUB: nxt = S_MEM;
                    OP_LDI, OP_ADDI, OP_SUBI,
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE,
                    OP_BLT, OP_BLE, OP_JMP:      nxt = S_EXEC;
                    default:                     nxt = S_ERROR;
                endcase
            end
            S_EXEC: begin
                nxt = done_st;
                case (op_q)
                    OP_LDI: begin
                        acc_wr_out    = 1'b1;
                        sel_A_out     = 2'b01;
                        status_wr_out = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        acc_wr_out    = 1'b1;
                        sel_A_out     = 2'b10;
                        sel_B_out     = 1'b1;
                        alu_op_out    = (op_q == OP_SUBI);
                        status_wr_out = 1'b1;
                    end
                    default: begin
                        pc_wr_out  = taken;
                        branch_out = taken;
                    end
                endcase
            end
            S_MEM: begin
                data_memory_req_out = 1'b1;
                data_memory_wr_out  = (op_q == OP_STO);
                if (data_mem_ready_in)
                    nxt = (op_q == OP_STO) ? done_st : S_WB;
                else if (wait_cnt == CNT_LAST)
                    nxt = S_ERROR;
            end
            S_WB: begin
                nxt           = done_st;
                acc_wr_out    = 1'b1;
                status_wr_out = 1'b1;
                if (op_q != OP_LD) begin
                    sel_A_out  = 2'b10;
                    alu_op_out = (op_q == OP_SUB);
                end
            end
            S_HALT:  halted_out    = 1'b1;
            S_ERROR: bus_error_out = 1'b1;
            default: nxt = S_IDLE;
        endcase

        // Reset masks everything immediately so no request or strobe leaks
        // out during the cycle in which the reset edge arrives.
        if (!reset_in) begin
            instr_mem_req_out   = 1'b0;
            data_memory_req_out = 1'b0;
            data_memory_wr_out  = 1'b0;
            branch_out          = 1'b0;
            sel_A_out           = 2'b00;
            sel_B_out           = 1'b0;
            alu_op_out          = 1'b0;
            acc_wr_out          = 1'b0;
            pc_wr_out           = 1'b0;
            status_wr_out       = 1'b0;
            ir_wr_out           = 1'b0;
            halted_out          = 1'b0;
            bus_error_out       = 1'b0;
            state_out           = 3'd0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Each instruction is expanded from its
// opcode, wait counts and flags into a per-cycle list of inputs and expected
// outputs. A negedge process compares the DUT against that list every cycle.
module tb_control_sequencer;
    localparam int OW = 5;
    localparam int T  = 16;

    logic clock_in = 1'b0, reset_in = 1'b0, run_in = 1'b0;
    logic [OW-1:0] op_code = '0;
    logic status_Z_in = 1'b0, status_N_in = 1'b0;
    logic instr_mem_ready_in = 1'b0, data_mem_ready_in = 1'b0;
    logic instr_mem_req_out, data_memory_req_out, data_memory_wr_out, branch_out;
    logic [1:0] sel_A_out;
    logic sel_B_out, alu_op_out, acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out;
    logic halted_out, bus_error_out;
    logic [2:0] state_out;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    logic step_mode_in = 1'b0;
`endif

    control_sequencer #(.OPCODE_WIDTH(OW), .TIMEOUT_CYCLES(T)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .run_in(run_in),
`ifdef CTRL_SEQ_SINGLE_STEP_EN
        .step_mode_in(step_mode_in),
`endif
        .op_code(op_code), .status_Z_in(status_Z_in), .status_N_in(status_N_in),
        .instr_mem_ready_in(instr_mem_ready_in), .data_mem_ready_in(data_mem_ready_in),
        .instr_mem_req_out(instr_mem_req_out), .data_memory_req_out(data_memory_req_out),
        .data_memory_wr_out(data_memory_wr_out), .branch_out(branch_out),
        .sel_A_out(sel_A_out), .sel_B_out(sel_B_out), .alu_op_out(alu_op_out),
        .acc_wr_out(acc_wr_out), .pc_wr_out(pc_wr_out), .status_wr_out(status_wr_out),
        .ir_wr_out(ir_wr_out), .halted_out(halted_out), .bus_error_out(bus_error_out),
        .state_out(state_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic instr_req, dreq, dwr, branch;
        logic [1:0] sel_a;
        logic sel_b, alu, acc_wr, pc_wr, st_wr, ir_wr, halted, berr;
        logic [2:0] st;
    } outv_t;

    outv_t act;
    assign act = '{instr_mem_req_out, data_memory_req_out, data_memory_wr_out, branch_out,
                   sel_A_out, sel_B_out, alu_op_out, acc_wr_out, pc_wr_out, status_wr_out,
                   ir_wr_out, halted_out, bus_error_out, state_out};

    outv_t expq[$];
    string nmq[$];
    outv_t trace[$];
    int n_cmp = 0, n_bad = 0, ncyc = 0;

    always @(negedge clock_in) begin : cmp
        outv_t e;
        string nm;
        if (expq.size() > 0) begin
            e  = expq.pop_front();
            nm = nmq.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", nm, trace.size(), act, e);
            end
            trace.push_back(act);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [OW-1:0] rop();
        return OW'($urandom_range(0, 31));
    endfunction
    function automatic outv_t ex(input logic [2:0] s);
        outv_t e = '0;
        e.st = s;
        return e;
    endfunction
    function automatic bit br_taken(input int op, input logic z, input logic n);
        case (op)
            8:  return z;
            9:  return !z;
            10: return !z && !n;
            11: return !n;
            12: return n;
            13: return z || n;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic run, input logic [OW-1:0] op,
                       input logic zf, input logic nf, input logic ir, input logic dr,
                       input outv_t e, input string nm);
        reset_in = rst; run_in = run; op_code = op;
        status_Z_in = zf; status_N_in = nf;
        instr_mem_ready_in = ir; data_mem_ready_in = dr;
        expq.push_back(e); nmq.push_back(nm); ncyc++;
        @(posedge clock_in); #1;
    endtask

    task automatic lit(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, a, e);
        end
    endtask

    // Sticky terminal states: inputs, including run_in, must not move them.
    task automatic tail(input logic [2:0] s, input string nm);
        outv_t e = ex(s);
        e.halted = (s == 3'd6);
        e.berr   = (s == 3'd7);
        for (int i = 0; i < 3; i++) cyc(1, 1'b1, rop(), rb(), rb(), rb(), rb(), e, nm);
    endtask

    task automatic start(input bit do_reset, input int idle_cycles);
        if (do_reset) begin
            cyc(0, rb(), rop(), rb(), rb(), rb(), rb(), ex(0), "reset");
            cyc(0, rb(), rop(), rb(), rb(), rb(), rb(), ex(0), "reset");
        end
        for (int i = 0; i < idle_cycles; i++) cyc(1, 0, rop(), rb(), rb(), rb(), rb(), ex(0), "idle");
        cyc(1, 1, rop(), rb(), rb(), rb(), rb(), ex(0), "idle_run");
    endtask

    // Runs one instruction that starts in FETCH. zf/nf < 0 means random flags.
    // abort >= 0 asserts reset during that MEM wait cycle.
    task automatic do_instr(input int op, input int fw, input int mw, input int zf,
                            input int nf, input int abort, output bit term);
        outv_t e;
        logic z, n;
        logic [OW-1:0] opv;
        bit tk;
        opv  = op[OW-1:0];
        term = 1'b0;
        for (int i = 0; i < fw && i < T; i++) begin
            e = ex(1); e.instr_req = 1'b1;
            cyc(1, rb(), rop(), rb(), rb(), 1'b0, rb(), e, "fetch_wait");
        end
        if (fw >= T) begin tail(3'd7, "fetch_timeout"); term = 1'b1; return; end
        e = ex(1); e.instr_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        cyc(1, rb(), rop(), rb(), rb(), 1'b1, rb(), e, "fetch_rdy");
        cyc(1, rb(), opv, rb(), rb(), rb(), rb(), ex(2), "decode");
        if (op == 0) begin tail(3'd6, "halt"); term = 1'b1; return; end
        if (op >= 15) begin tail(3'd7, "bad_opcode"); term = 1'b1; return; end
        if (op == 1 || op == 2 || op == 4 || op == 6) begin
            for (int i = 0; i < mw && i < T; i++) begin
                if (i == abort) begin
                    cyc(0, rb(), rop(), rb(), rb(), rb(), 1'b0, ex(0), "reset_mid_mem");
                    cyc(1, 1'b0, rop(), rb(), rb(), rb(), rb(), ex(0), "idle_after_reset");
                    term = 1'b1;
                    return;
                end
                e = ex(4); e.dreq = 1'b1; e.dwr = (op == 1);
                cyc(1, rb(), rop(), rb(), rb(), rb(), 1'b0, e, "mem_wait");
            end
            if (mw >= T) begin tail(3'd7, "mem_timeout"); term = 1'b1; return; end
            e = ex(4); e.dreq = 1'b1; e.dwr = (op == 1);
            cyc(1, rb(), rop(), rb(), rb(), rb(), 1'b1, e, "mem_rdy");
            if (op != 1) begin
                e = ex(5); e.acc_wr = 1'b1; e.st_wr = 1'b1;
                if (op != 2) begin e.sel_a = 2'b10; e.alu = (op == 6); end
                cyc(1, rb(), rop(), rb(), rb(), rb(), rb(), e, "wb");
            end
        end else begin
            z = (zf < 0) ? rb() : zf[0];
            n = (nf < 0) ? rb() : nf[0];
            e = ex(3);
            if (op == 3) begin
                e.acc_wr = 1'b1; e.sel_a = 2'b01; e.st_wr = 1'b1;
            end else if (op == 5 || op == 7) begin
                e.acc_wr = 1'b1; e.sel_a = 2'b10; e.sel_b = 1'b1; e.st_wr = 1'b1;
                e.alu = (op == 7);
            end else begin
                tk = br_taken(op, z, n);
                e.pc_wr = tk; e.branch = tk;
            end
            cyc(1, rb(), rop(), z, n, rb(), rb(), e, "exec");
        end
    endtask

    initial begin
        bit term;
        int m, op, fw, mw, r;
        @(posedge clock_in); #1;

        // Reset, start and one LDI with zero-wait fetch.
        start(1, 0);
        m = ncyc;
        do_instr(3, 0, 0, -1, -1, -1, term);
        e_next_fetch();
        lit("rst_state", int'(trace[1].st), 0);
        lit("start_fetch_req", int'(trace[m].instr_req), 1);
        lit("ldi_selA", int'(trace[m+2].sel_a), 1);
        lit("ldi_back_in_fetch", int'(trace[m+3].st), 1);

        // ADD with 3 wait cycles, then a set of branches.
        m = ncyc;
        do_instr(4, 0, 3, -1, -1, -1, term);
        lit("add_mem_4th_cycle", int'(trace[m+5].st), 4);
        lit("add_wb_selA", int'(trace[m+6].sel_a), 2);
        do_instr(1, 1, 2, -1, -1, -1, term);
        m = ncyc;
        do_instr(10, 0, 0, 0, 0, -1, term);
        lit("bgt_taken", int'(trace[m+2].branch), 1);
        do_instr(10, 0, 0, 1, 0, -1, term);
        do_instr(13, 0, 0, 0, 1, -1, term);
        do_instr(9, 0, 0, 1, 0, -1, term);
        do_instr(14, 0, 0, -1, -1, -1, term);

        // Ready in the last allowed cycle is accepted; one more wait is not.
        m = ncyc;
        do_instr(2, 0, T - 1, -1, -1, -1, term);
        lit("ready_on_last_cycle_wb", int'(trace[m+T+2].st), 5);
        m = ncyc;
        do_instr(1, 0, T, -1, -1, -1, term);
        lit("timeout_last_mem", int'(trace[m+T+1].st), 4);
        lit("timeout_error", int'(trace[m+T+2].st), 7);

        start(1, 1);
        do_instr(31, 0, 0, -1, -1, -1, term);
        start(1, 0);
        do_instr(0, 2, 0, -1, -1, -1, term);
        start(1, 0);
        m = ncyc;
        do_instr(6, 0, 5, -1, -1, 1, term);
        lit("reset_drops_dreq", int'(trace[m+3].dreq), 0);
        lit("idle_after_reset_edge", int'(trace[m+4].st), 0);
        start(0, 0);
        do_instr(0, 0, 0, -1, -1, -1, term);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            start(1, $urandom_range(0, 2));
            for (int k = 0; k < 20; k++) begin
                r  = $urandom_range(0, 99);
                op = (r < 3) ? 0 : (r < 6) ? $urandom_range(15, 31) : $urandom_range(1, 14);
                r  = $urandom_range(0, 39);
                fw = (r < 32) ? $urandom_range(0, 3) : (r < 36) ? T - 1 : (r < 37) ? T : $urandom_range(4, 8);
                r  = $urandom_range(0, 39);
                mw = (r < 30) ? $urandom_range(0, 3) : (r < 35) ? T - 1 : (r < 37) ? T : $urandom_range(4, 10);
                do_instr(op, fw, mw, -1, -1, ($urandom_range(0, 29) == 0) ? 0 : -1, term);
                if (term) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // One extra FETCH cycle so the return from the directed LDI is traced.
    task automatic e_next_fetch();
        outv_t e;
        e = ex(1); e.instr_req = 1'b1;
        cyc(1, rb(), rop(), rb(), rb(), 1'b0, rb(), e, "fetch_wait");
        e = ex(1); e.instr_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        cyc(1, rb(), rop(), rb(), rb(), 1'b1, rb(), e, "fetch_rdy");
        cyc(1, rb(), OW'(3), rb(), rb(), rb(), rb(), ex(2), "decode");
        e = ex(3); e.acc_wr = 1'b1; e.sel_a = 2'b01; e.st_wr = 1'b1;
        cyc(1, rb(), rop(), rb(), rb(), rb(), rb(), e, "exec");
    endtask

endmodule
